// File: rtl/pong_turn_controller_pkg.sv
// -----------------------------------------------------------------------------
// pong_game_pkg
// Shared definitions for the pong-toss turn controller:
//   - FSM state encodings (3-bit, legacy-compatible localparams)
//   - cup point table (cup i is worth i+1 points)
//   - score width / saturation limit
//   - helpers: highest-cup point lookup, saturating score add
// -----------------------------------------------------------------------------
package pong_game_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_TURN_START = 3'd1;
    localparam logic [2:0] ST_AIM        = 3'd2;
    localparam logic [2:0] ST_LOCKOUT    = 3'd3;
    localparam logic [2:0] ST_TURN_END   = 3'd4;
    localparam logic [2:0] ST_GAME_OVER  = 3'd5;

    localparam int               SCORE_W   = 6;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 6'd63;

    localparam logic [1:0] CUP_POINTS [0:2] = '{2'd1, 2'd2, 2'd3};

    // Only the highest-numbered cup that fired is scored.
    function automatic logic [1:0] cup_points(input logic [2:0] hit);
        if (hit[2])      return CUP_POINTS[2];
        else if (hit[1]) return CUP_POINTS[1];
        else if (hit[0]) return CUP_POINTS[0];
        else             return 2'd0;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] score,
                                                   input logic [1:0]         pts);
        logic [SCORE_W:0] sum;
        sum = {1'b0, score} + {{(SCORE_W-1){1'b0}}, pts};
        return (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/pong_turn_controller_if.sv
// -----------------------------------------------------------------------------
// pong_turn_controller_if
// Game-side signal bundle of the turn controller.
//   start         : one-cycle start pulse (debounced, edge-detected)
//   hit_pulse[2:0]: one-cycle per-cup sensor pulses
//   active_player, score_p0, score_p1, shots_left, sensor_armed, lockout,
//   game_over, winner, state_dbg : display / LED outputs
// Modports: master (stimulus side), slave (controller side).
// -----------------------------------------------------------------------------
interface pong_turn_controller_if;
    import pong_game_pkg::*;

    logic               start;
    logic [2:0]         hit_pulse;
    logic               active_player;
    logic [SCORE_W-1:0] score_p0;
    logic [SCORE_W-1:0] score_p1;
    logic [2:0]         shots_left;
    logic               sensor_armed;
    logic               lockout;
    logic               game_over;
    logic               winner;
    logic [2:0]         state_dbg;

    modport master (
        output start, hit_pulse,
        input  active_player, score_p0, score_p1, shots_left,
               sensor_armed, lockout, game_over, winner, state_dbg
    );

    modport slave (
        input  start, hit_pulse,
        output active_player, score_p0, score_p1, shots_left,
               sensor_armed, lockout, game_over, winner, state_dbg
    );

endinterface

// File: rtl/pong_turn_controller_phase_timer.sv
// -----------------------------------------------------------------------------
// pong_phase_timer
// Clearable up-counter with terminal-count compare, shared by the AIM and
// LOCKOUT phases.
//   clk, reset : clock, async active-high reset
//   i_clear    : synchronous clear to 0 (wins over i_enable)
//   i_enable   : count up by one this cycle
//   i_limit    : phase length in cycles
//   o_done     : high while count == i_limit-1
// -----------------------------------------------------------------------------
module pong_phase_timer #(
    parameter int TIMER_W = 30
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_enable,
    input  logic [TIMER_W-1:0] i_limit,
    output logic               o_done
);

    logic [TIMER_W-1:0] r_count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of block ordering in simulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_enable)
            r_count <= r_count + 1'b1;
    end

    assign o_done = (r_count == i_limit - 1'b1);

endmodule

// File: rtl/pong_turn_controller.sv
// -----------------------------------------------------------------------------
// pong_turn_controller
// Two-player pong-toss sequencer: alternates turns of SHOTS_PER_TURN shots,
// scores the highest cup hit, enforces an aim timeout (miss) and a post-shot
// sensor lockout, and declares a winner at WIN_SCORE.
//   clk_100MHz : system clock
//   reset      : asynchronous, active-high
//   bus        : pong_turn_controller_if.slave (start/hit in, display out)
// All outputs are flops or decodes of the registered state.
// -----------------------------------------------------------------------------
module pong_turn_controller
    import pong_game_pkg::*;
#(
    parameter int SHOTS_PER_TURN = 5,
    parameter int WIN_SCORE      = 21,
    parameter int AIM_CYCLES     = 1_000_000_000,
    parameter int LOCKOUT_CYCLES = 500_000_000,
    parameter int TIMER_W        = 30
) (
    input  logic                  clk_100MHz,
    input  logic                  reset,
    pong_turn_controller_if.slave bus
);

    localparam logic [TIMER_W-1:0] AIM_LIMIT     = TIMER_W'(AIM_CYCLES);
    localparam logic [TIMER_W-1:0] LOCKOUT_LIMIT = TIMER_W'(LOCKOUT_CYCLES);
    localparam logic [SCORE_W-1:0] WIN_LIMIT     = SCORE_W'(WIN_SCORE);
    localparam logic [2:0]         SHOTS_INIT    = 3'(SHOTS_PER_TURN);

    logic [2:0]         r_state;
    logic               r_active_player;
    logic               r_winner;
    logic [SCORE_W-1:0] r_score_p0;
    logic [SCORE_W-1:0] r_score_p1;
    logic [2:0]         r_shots_left;

    logic               w_hit;
    logic [1:0]         w_points;
    logic [SCORE_W-1:0] w_active_score;
    logic [TIMER_W-1:0] w_limit;
    logic               w_timer_en;
    logic               w_timer_clear;
    logic               w_timer_done;

    assign w_hit          = |bus.hit_pulse;
    assign w_points       = cup_points(bus.hit_pulse);
    assign w_active_score = r_active_player ? r_score_p1 : r_score_p0;

    // One timer serves both timed phases; its limit follows the state.
    assign w_limit       = (r_state == ST_LOCKOUT) ? LOCKOUT_LIMIT : AIM_LIMIT;
    assign w_timer_en    = (r_state == ST_AIM) || (r_state == ST_LOCKOUT);
    // Held at zero outside timed phases so each phase starts from 0; a hit
    // or terminal count ends the phase and restarts the count.
    assign w_timer_clear = !w_timer_en || ((r_state == ST_AIM) && w_hit) || w_timer_done;

    pong_phase_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk      (clk_100MHz),
        .reset    (reset),
        .i_clear  (w_timer_clear),
        .i_enable (w_timer_en),
        .i_limit  (w_limit),
        .o_done   (w_timer_done)
    );

    // NOTE: asynchronous reset appears in the sensitivity list so outputs
    // clear the instant reset rises, not at the next clock edge.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_active_player <= 1'b0;
            r_winner        <= 1'b0;
            r_score_p0      <= '0;
            r_score_p1      <= '0;
            r_shots_left    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_score_p0      <= '0;
                        r_score_p1      <= '0;
                        r_active_player <= 1'b0;
                        r_winner        <= 1'b0;
                        r_state         <= ST_TURN_START;
                    end
                end
                ST_TURN_START: begin
                    r_shots_left <= SHOTS_INIT;
                    r_state      <= ST_AIM;
                end
                ST_AIM: begin
                    // A hit coinciding with the timeout still scores.
                    if (w_hit) begin
                        if (r_active_player)
                            r_score_p1 <= sat_add(r_score_p1, w_points);
                        else
                            r_score_p0 <= sat_add(r_score_p0, w_points);
                        r_shots_left <= r_shots_left - 1'b1;
                        r_state      <= ST_LOCKOUT;
                    end else if (w_timer_done) begin
                        r_shots_left <= r_shots_left - 1'b1;
                        r_state      <= ST_LOCKOUT;
                    end
                end
                ST_LOCKOUT: begin
                    if (w_timer_done) begin
                        if (w_active_score >= WIN_LIMIT) begin
                            r_winner <= r_active_player;
                            r_state  <= ST_GAME_OVER;
                        end else if (r_shots_left == 3'd0) begin
                            r_state <= ST_TURN_END;
                        end else begin
                            r_state <= ST_AIM;
                        end
                    end
                end
                ST_TURN_END: begin
                    r_active_player <= ~r_active_player;
                    r_state         <= ST_TURN_START;
                end
                ST_GAME_OVER: begin
                    if (bus.start)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.active_player = r_active_player;
    assign bus.score_p0      = r_score_p0;
    assign bus.score_p1      = r_score_p1;
    assign bus.shots_left    = r_shots_left;
    assign bus.winner        = r_winner;
    assign bus.state_dbg     = r_state;
    assign bus.sensor_armed  = (r_state == ST_AIM);
    assign bus.lockout       = (r_state == ST_LOCKOUT);
    assign bus.game_over     = (r_state == ST_GAME_OVER);

endmodule

// File: tb/tb_pong_turn_controller.sv
// -----------------------------------------------------------------------------
// tb_pong_turn_controller
// Directed bench for pong_turn_controller with shortened timing:
// AIM_CYCLES=20, LOCKOUT_CYCLES=8, SHOTS_PER_TURN=2, WIN_SCORE=5.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_pong_turn_controller;

    logic clk_100MHz = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    pong_turn_controller_if bus ();

    pong_turn_controller #(
        .SHOTS_PER_TURN (2),
        .WIN_SCORE      (5),
        .AIM_CYCLES     (20),
        .LOCKOUT_CYCLES (8),
        .TIMER_W        (30)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .bus        (bus)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_100MHz);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"},   32'(bus.state_dbg),     0);
        check({tag, "_p0"},      32'(bus.score_p0),      0);
        check({tag, "_p1"},      32'(bus.score_p1),      0);
        check({tag, "_shots"},   32'(bus.shots_left),    0);
        check({tag, "_player"},  32'(bus.active_player), 0);
        check({tag, "_armed"},   32'(bus.sensor_armed),  0);
        check({tag, "_lockout"}, 32'(bus.lockout),       0);
        check({tag, "_over"},    32'(bus.game_over),     0);
        check({tag, "_winner"},  32'(bus.winner),        0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.hit_pulse = 3'b000;
        #2;
        check_all_zero("reset");

        step(1);
        reset = 1'b0;
        step(1);
        check("idle_hold", 32'(bus.state_dbg), 0);

        // Start: one cycle of TURN_START, then AIM for player 0.
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        check("turn_start", 32'(bus.state_dbg), 1);
        step(1);
        check("aim_state",  32'(bus.state_dbg),     2);
        check("aim_shots",  32'(bus.shots_left),    2);
        check("aim_player", 32'(bus.active_player), 0);
        check("aim_armed",  32'(bus.sensor_armed),  1);

        // Cup 2 hit: +3, one shot used, lockout next cycle.
        bus.hit_pulse = 3'b100;
        step(1);
        bus.hit_pulse = 3'b000;
        check("hit3_p0",      32'(bus.score_p0),     3);
        check("hit3_shots",   32'(bus.shots_left),   1);
        check("hit3_lockout", 32'(bus.lockout),      1);
        check("hit3_armed",   32'(bus.sensor_armed), 0);

        // Hits during lockout are ignored.
        bus.hit_pulse = 3'b111;
        step(1);
        bus.hit_pulse = 3'b000;
        check("lock_ignore_p0", 32'(bus.score_p0), 3);
        step(6);
        check("lock_still", 32'(bus.state_dbg), 3);
        step(1);
        check("lock_to_aim", 32'(bus.state_dbg), 2);

        // Aim timeout: 20 cycles without a hit is a miss.
        step(19);
        check("miss_pending", 32'(bus.state_dbg), 2);
        step(1);
        check("miss_state", 32'(bus.state_dbg),  3);
        check("miss_shots", 32'(bus.shots_left), 0);
        check("miss_p0",    32'(bus.score_p0),   3);

        // Out of shots: lockout -> TURN_END -> TURN_START for player 1.
        step(8);
        check("turn_end", 32'(bus.state_dbg), 4);
        step(1);
        check("p1_turn_start", 32'(bus.state_dbg),     1);
        check("p1_player",     32'(bus.active_player), 1);
        step(1);
        check("p1_aim",   32'(bus.state_dbg),  2);
        check("p1_shots", 32'(bus.shots_left), 2);

        // Hit on the timeout cycle counts as a hit (+3 for cup 2).
        step(19);
        bus.hit_pulse = 3'b100;
        step(1);
        bus.hit_pulse = 3'b000;
        check("tie_p1",    32'(bus.score_p1),   3);
        check("tie_p0",    32'(bus.score_p0),   3);
        check("tie_shots", 32'(bus.shots_left), 1);
        step(8);
        check("p1_shot2_aim", 32'(bus.state_dbg), 2);

        // 3'b011 scores only cup 1 (+2), reaching WIN_SCORE.
        bus.hit_pulse = 3'b011;
        step(1);
        bus.hit_pulse = 3'b000;
        check("hit011_p1",    32'(bus.score_p1),   5);
        check("hit011_shots", 32'(bus.shots_left), 0);
        step(7);
        check("win_pending", 32'(bus.state_dbg), 3);
        step(1);
        check("win_state",   32'(bus.state_dbg), 5);
        check("win_over",    32'(bus.game_over), 1);
        check("win_winner",  32'(bus.winner),    1);
        check("win_lockout", 32'(bus.lockout),   0);

        // start from GAME_OVER -> IDLE, scores held.
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        check("go_idle",    32'(bus.state_dbg), 0);
        check("go_idle_p0", 32'(bus.score_p0),  3);
        check("go_idle_p1", 32'(bus.score_p1),  5);
        check("go_over_lo", 32'(bus.game_over), 0);

        // Second start clears scores and hands the turn to player 0.
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        check("restart_state",  32'(bus.state_dbg),     1);
        check("restart_p0",     32'(bus.score_p0),      0);
        check("restart_p1",     32'(bus.score_p1),      0);
        check("restart_player", 32'(bus.active_player), 0);
        step(1);

        // start during AIM is ignored.
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        check("start_in_aim", 32'(bus.state_dbg), 2);

        // Cup 0 hit (+1), then async reset in the middle of the lockout.
        bus.hit_pulse = 3'b001;
        step(1);
        bus.hit_pulse = 3'b000;
        check("hit1_p0",      32'(bus.score_p0), 1);
        check("hit1_lockout", 32'(bus.lockout),  1);
        step(3);
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        step(1);
        reset = 1'b0;
        step(2);
        check("post_reset_idle", 32'(bus.state_dbg), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
